// File: rtl/trena_digital_uc_n.sv
// Control unit for the digital tape-measure: one measurement, then NUM_DIGITS+1 serial characters.
// Optional measurement timeout enabled by defining TRENA_TIMEOUT_EN.
//
// state              | meaning
// -------------------+--------------------------------------------------
// INICIAL      (0)   | idle, waits for ligar && mensurar
// FAZ_MEDIDA   (1)   | one-cycle sensor trigger, timer cleared
// AGUARDA_MEDIDA (2) | waits for medida_pronto (or timeout)
// TRANSMITE    (3)   | one-cycle TX start for character idx
// ESPERA_TRANSMISSAO (4) | waits for envio_pronto
// ESPERA_PERIODO (6) | continuous mode idle period before next measurement
// ERRO         (E)   | one-cycle timeout indication
// FIM          (F)   | one-cycle end-of-sequence pulse
module trena_digital_uc_n #(
    parameter int NUM_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PERIOD_CYCLES  = 5000000,
    localparam int SEL_W         = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ligar,
    input  logic             mensurar,
    input  logic             modo_continuo,
    input  logic             medida_pronto,
    input  logic             envio_pronto,
    output logic             medir,
    output logic             transmitir,
    output logic [SEL_W-1:0] sel_caracter,
    output logic             pronto,
    output logic             erro_timeout,
    output logic [3:0]       db_estado
);

    // One counter serves both the timeout and the period, so size it for the larger.
    localparam int MAX_CYC = (TIMEOUT_CYCLES > PERIOD_CYCLES) ? TIMEOUT_CYCLES : PERIOD_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        INICIAL            = 4'h0,
        FAZ_MEDIDA         = 4'h1,
        AGUARDA_MEDIDA     = 4'h2,
        TRANSMITE          = 4'h3,
        ESPERA_TRANSMISSAO = 4'h4,
        ESPERA_PERIODO     = 4'h6,
        ERRO               = 4'hE,
        FIM                = 4'hF
    } state_t;

    state_t             state, state_next;
    logic [SEL_W-1:0]   idx, idx_next;
    logic [TMR_W-1:0]   timer, timer_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INICIAL;
            idx   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        timer_next = timer;
        case (state)
            INICIAL: begin
                if (ligar && mensurar) begin
                    state_next = FAZ_MEDIDA;
                end
            end
            FAZ_MEDIDA: begin
                timer_next = '0;
                state_next = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                // A result arriving on the timeout cycle still counts as a valid measurement.
                if (medida_pronto) begin
                    idx_next   = '0;
                    state_next = TRANSMITE;
                end
`ifdef TRENA_TIMEOUT_EN
                else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ERRO;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
`endif
            end
            TRANSMITE: begin
                state_next = ESPERA_TRANSMISSAO;
            end
            ESPERA_TRANSMISSAO: begin
                if (envio_pronto) begin
                    if (idx == SEL_W'(NUM_DIGITS)) begin
                        state_next = FIM;
                    end else begin
                        idx_next   = idx + SEL_W'(1);
                        state_next = TRANSMITE;
                    end
                end
            end
            FIM: begin
                idx_next   = '0;
                timer_next = '0;
                if (modo_continuo && ligar) begin
                    state_next = ESPERA_PERIODO;
                end else begin
                    state_next = INICIAL;
                end
            end
            ESPERA_PERIODO: begin
                if (!ligar) begin
                    state_next = INICIAL;
                end else if (timer == TMR_W'(PERIOD_CYCLES - 1)) begin
                    state_next = FAZ_MEDIDA;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            ERRO: begin
                state_next = INICIAL;
            end
            default: begin
                state_next = INICIAL;
            end
        endcase
    end

    always_comb begin
        medir        = (state == FAZ_MEDIDA);
        transmitir   = (state == TRANSMITE);
        pronto       = (state == FIM);
        sel_caracter = idx;
        db_estado    = state;
`ifdef TRENA_TIMEOUT_EN
        erro_timeout = (state == ERRO);
`else
        erro_timeout = 1'b0;
`endif
    end

endmodule

// File: tb/tb_trena_digital_uc_n.sv
// Scoreboard bench for trena_digital_uc_n: expected character indices queued per measurement,
// popped on each transmitir; timeout checks only when TRENA_TIMEOUT_EN is defined.
module tb_trena_digital_uc_n;

    localparam int ND  = 3;
    localparam int ND5 = 5;
    localparam int TO  = 16;
    localparam int PER = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ligar = 1'b0, ligar5 = 1'b0, mensurar = 1'b0, modo_continuo = 1'b0;
    logic medida_pronto = 1'b0, envio_pronto = 1'b0;

    logic medir3, tx3, pronto3, err3;
    logic [1:0] sel3;
    logic [3:0] db3;
    logic medir5, tx5, pronto5, err5;
    logic [2:0] sel5;
    logic [3:0] db5;

    bit use5 = 1'b0;
    logic m_medir, m_tx, m_pronto, m_err;
    logic [2:0] m_sel;
    logic [3:0] m_db;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    always #5 clock = ~clock;

    trena_digital_uc_n #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)) u_dut (
        .clock(clock), .reset_n(reset_n), .ligar(ligar), .mensurar(mensurar),
        .modo_continuo(modo_continuo), .medida_pronto(medida_pronto), .envio_pronto(envio_pronto),
        .medir(medir3), .transmitir(tx3), .sel_caracter(sel3), .pronto(pronto3),
        .erro_timeout(err3), .db_estado(db3)
    );

    trena_digital_uc_n #(.NUM_DIGITS(ND5), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .ligar(ligar5), .mensurar(mensurar),
        .modo_continuo(modo_continuo), .medida_pronto(medida_pronto), .envio_pronto(envio_pronto),
        .medir(medir5), .transmitir(tx5), .sel_caracter(sel5), .pronto(pronto5),
        .erro_timeout(err5), .db_estado(db5)
    );

    always_comb begin
        m_medir  = use5 ? medir5  : medir3;
        m_tx     = use5 ? tx5     : tx3;
        m_pronto = use5 ? pronto5 : pronto3;
        m_err    = use5 ? err5    : err3;
        m_sel    = use5 ? sel5    : {1'b0, sel3};
        m_db     = use5 ? db5     : db3;
    end

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        mensurar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Runs one measurement to its pronto pulse; leaves the bench at the negedge showing FIM.
    task automatic run_seq(input int nd, input bit started, input int med_delay, input int tx_delay);
        int med_cnt, tx_cnt, n_tx, exp_sel, cur_sel;
        bit done;
        sb.delete();
        for (int i = 0; i <= nd; i++) sb.push_back(i);
        med_cnt = started ? med_delay : -1;
        tx_cnt = -1; n_tx = 0; cur_sel = -1; done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clock);
            medida_pronto = 1'b0;
            envio_pronto  = 1'b0;
            if (m_medir) begin
                mensurar = 1'b0;
                med_cnt  = med_delay;
            end else if (med_cnt > 0) begin
                med_cnt--;
                if (med_cnt == 0) begin
                    medida_pronto = 1'b1;
                    med_cnt = -1;
                end
            end
            if (m_tx) begin
                n_tx++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_transmitir: sel_caracter=%0d, queue empty", m_sel);
                end else begin
                    exp_sel = sb.pop_front();
                    cur_sel = exp_sel;
                    if (m_sel !== exp_sel) begin
                        n_fail++;
                        $display("FAIL sel_order: got %0d expected %0d", m_sel, exp_sel);
                    end
                end
                tx_cnt = tx_delay;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    n_checks++;
                    if (m_sel !== cur_sel) begin
                        n_fail++;
                        $display("FAIL sel_stable: got %0d expected %0d", m_sel, cur_sel);
                    end
                    envio_pronto = 1'b1;
                    tx_cnt = -1;
                end
            end
            if (m_err !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_erro: erro_timeout=%b expected 0", m_err);
            end
            if (m_pronto) begin
                done = 1'b1;
                n_checks++;
                if (n_tx != nd + 1 || sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL tx_count: got %0d pulses expected %0d (left in queue %0d)",
                             n_tx, nd + 1, sb.size());
                end
            end
        end
        medida_pronto = 1'b0;
        envio_pronto  = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL seq_timeout: pronto not seen, expected within 3000 cycles");
        end
    endtask

    task automatic wait_medir(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (m_medir) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL medir_wait: medir=0 expected 1 within 20 cycles");
        end
        mensurar = 1'b0;
    endtask

    task automatic test_reset();
        use5 = 1'b0;
        apply_reset();
        n_checks++;
        if ({medir3, tx3, pronto3, err3, sel3, db3} !== 10'b0 ||
            {medir5, tx5, pronto5, err5, sel5, db5} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_state: dut3=%b dut5=%b expected all 0",
                     {medir3, tx3, pronto3, err3, sel3, db3}, {medir5, tx5, pronto5, err5, sel5, db5});
        end
    endtask

    task automatic test_single();
        use5 = 1'b0; ligar = 1'b1; modo_continuo = 1'b0; mensurar = 1'b1;
        run_seq(ND, 1'b0, 5, 10);
        @(negedge clock);
        n_checks++;
        if (m_pronto !== 1'b0 || m_db !== 4'h0) begin
            n_fail++;
            $display("FAIL single_return: pronto=%b db_estado=%h expected 0/0", m_pronto, m_db);
        end
    endtask

    task automatic test_timeout();
        bit seen, saw_tx, saw_err;
        int cnt;
        use5 = 1'b0; ligar = 1'b1; modo_continuo = 1'b0; mensurar = 1'b1;
        wait_medir(seen);
        cnt = 0; saw_tx = 1'b0; saw_err = 1'b0;
`ifdef TRENA_TIMEOUT_EN
        for (int i = 0; i < 40 && !saw_err; i++) begin
            @(negedge clock);
            cnt++;
            if (m_tx) saw_tx = 1'b1;
            if (m_err) saw_err = 1'b1;
        end
        n_checks++;
        if (!saw_err || cnt != TO + 1 || saw_tx || m_db !== 4'hE) begin
            n_fail++;
            $display("FAIL timeout_latency: err=%b after %0d cycles tx=%b db=%h expected 1 after %0d, tx=0, db=E",
                     saw_err, cnt, saw_tx, m_db, TO + 1);
        end
        @(negedge clock);
        n_checks++;
        if (m_err !== 1'b0 || m_db !== 4'h0) begin
            n_fail++;
            $display("FAIL timeout_return: err=%b db=%h expected 0/0", m_err, m_db);
        end
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (m_tx) saw_tx = 1'b1;
            if (m_err) saw_err = 1'b1;
        end
        n_checks++;
        if (saw_err || saw_tx || m_db !== 4'h2) begin
            n_fail++;
            $display("FAIL no_timeout_wait: err=%b tx=%b db=%h expected 0/0/2", saw_err, saw_tx, m_db);
        end
        apply_reset();
`endif
    endtask

    task automatic test_continuous();
        int cnt;
        bit seen;
        use5 = 1'b0; ligar = 1'b1; modo_continuo = 1'b1; mensurar = 1'b1;
        run_seq(ND, 1'b0, 5, 10);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            cnt++;
            if (m_medir) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cnt != PER + 1) begin
            n_fail++;
            $display("FAIL period_latency: medir after %0d cycles (seen=%b) expected %0d", cnt, seen, PER + 1);
        end
        run_seq(ND, 1'b1, 5, 10);
        repeat (3) @(negedge clock);
        ligar = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (m_medir) seen = 1'b1;
        end
        n_checks++;
        if (seen || m_db !== 4'h0) begin
            n_fail++;
            $display("FAIL period_abort: medir_seen=%b db=%h expected 0/0", seen, m_db);
        end
        modo_continuo = 1'b0;
        ligar = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit hit;
        int env_cnt;
        use5 = 1'b0; ligar = 1'b1; modo_continuo = 1'b0; mensurar = 1'b1;
        hit = 1'b0; env_cnt = -1;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clock);
            envio_pronto = 1'b0;
            if (m_medir) begin
                mensurar = 1'b0;
                medida_pronto = 1'b1;
            end
            if (m_tx) begin
                medida_pronto = 1'b0;
                if (m_sel == 3'd2) hit = 1'b1;
                else env_cnt = 3;
            end else if (env_cnt > 0) begin
                env_cnt--;
                if (env_cnt == 0) begin
                    envio_pronto = 1'b1;
                    env_cnt = -1;
                end
            end
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (!hit || m_db !== 4'h4 || m_sel !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: hit=%b db=%h sel=%0d expected 1/4/2", hit, m_db, m_sel);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_medir, m_tx, m_pronto, m_err, m_sel, m_db} !== 11'b0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%b expected all 0 before clock edge",
                     {m_medir, m_tx, m_pronto, m_err, m_sel, m_db});
        end
        @(negedge clock);
        reset_n = 1'b1;
        medida_pronto = 1'b0; envio_pronto = 1'b0;
        mensurar = 1'b1;
        run_seq(ND, 1'b0, 5, 10);
    endtask

    task automatic test_five();
        use5 = 1'b1; ligar = 1'b0; ligar5 = 1'b1; modo_continuo = 1'b0; mensurar = 1'b1;
        run_seq(ND5, 1'b0, 5, 10);
        @(negedge clock);
        n_checks++;
        if (db5 !== 4'h0 || db3 !== 4'h0) begin
            n_fail++;
            $display("FAIL five_return: db5=%h db3=%h expected 0/0", db5, db3);
        end
        ligar5 = 1'b0; use5 = 1'b0; ligar = 1'b1;
    endtask

    task automatic test_ligar_off();
        use5 = 1'b0; ligar = 1'b0;
        for (int p = 0; p < 4; p++) begin
            mensurar = 1'b1; medida_pronto = 1'b1; envio_pronto = 1'b1;
            repeat (2) @(negedge clock);
            mensurar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0;
            repeat (2) @(negedge clock);
            n_checks++;
            if (m_medir !== 1'b0 || m_db !== 4'h0) begin
                n_fail++;
                $display("FAIL ligar_off: medir=%b db=%h expected 0/0", m_medir, m_db);
            end
        end
        ligar = 1'b1;
    endtask

    task automatic test_race();
        bit seen;
        use5 = 1'b0; ligar = 1'b1; modo_continuo = 1'b0; mensurar = 1'b1;
        wait_medir(seen);
        repeat (TO) @(negedge clock);
        medida_pronto = 1'b1;
        @(negedge clock);
        medida_pronto = 1'b0;
        n_checks++;
        if (m_db !== 4'h3 || m_tx !== 1'b1 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pronto_vs_timeout: db=%h tx=%b err=%b expected 3/1/0", m_db, m_tx, m_err);
        end
        apply_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_continuous();
        test_reset_mid();
        test_five();
        test_ligar_off();
        test_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
